// File: rtl/poly_pipe_pkg.sv
// Shared types and constants for the polynomial coefficient pipeline.
// Holds the coefficient word, the modulus and the protocol-error cause codes.
package poly_pipe_pkg;

   localparam int unsigned COEF_W = 12;
   localparam logic [COEF_W-1:0] Q = 12'd3329;

   typedef logic [COEF_W-1:0] coef_t;

   // Only the first cause seen in a cycle is recorded; all causes set the same flag.
   typedef enum logic [1:0] {
      ERR_NONE     = 2'd0,
      ERR_CREDIT   = 2'd1,
      ERR_ORPHAN   = 2'd2,
      ERR_OVERFLOW = 2'd3
   } err_cause_e;

endpackage

// File: rtl/coef_fifo_ram.sv
// Circular coefficient store with wrapping write and read pointers.
// The read port is combinational, which gives first-word fall-through at the top.
module coef_fifo_ram #(
   parameter int DWIDTH = 12,
   parameter int DEPTH  = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              push_i,
   input  logic              pop_i,
   input  logic [DWIDTH-1:0] wr_data_i,
   output logic [DWIDTH-1:0] rd_data_o
);

   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [DWIDTH-1:0] mem_q [DEPTH];
   logic [PW-1:0]     wrPtr_q, wrPtr_d;
   logic [PW-1:0]     rdPtr_q, rdPtr_d;

   // An explicit compare wraps correctly when DEPTH is not a power of two.
   function automatic logic [PW-1:0] ptrInc(input logic [PW-1:0] p);
      return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   always_comb begin
      wrPtr_d = wrPtr_q;
      rdPtr_d = rdPtr_q;
      if (push_i) wrPtr_d = ptrInc(wrPtr_q);
      if (pop_i)  rdPtr_d = ptrInc(rdPtr_q);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wrPtr_q <= '0;
         rdPtr_q <= '0;
      end else begin
         wrPtr_q <= wrPtr_d;
         rdPtr_q <= rdPtr_d;
      end
   end

   always_ff @(posedge clk) begin
      if (push_i) mem_q[wrPtr_q] <= wr_data_i;
   end

   assign rd_data_o = mem_q[rdPtr_q];

endmodule

// File: rtl/coef_drain_fifo.sv
// Receive end of a fixed-latency coefficient pipe: buffers results, presents them
// on valid/ready and grants issue credits so nothing in flight is ever lost.
module coef_drain_fifo
   import poly_pipe_pkg::*;
#(
   parameter int DWIDTH = $bits(coef_t),
   parameter int LAT    = 3,
   parameter int DEPTH  = 4
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       issue_i,
   output logic                       issue_ok_o,
   input  logic                       res_valid_i,
   input  logic [DWIDTH-1:0]          res_data_i,
   output logic                       out_valid_o,
   output logic [DWIDTH-1:0]          out_data_o,
   input  logic                       out_ready_i,
   output logic [$clog2(DEPTH+1)-1:0] count_o,
   output logic                       err_o
);

   localparam int CW = $clog2(DEPTH + 1);
   localparam int IW = $clog2(LAT + 1);

   logic [CW-1:0]     count_q, count_d;
   logic [CW-1:0]     resv_q, resv_d;
   logic [IW-1:0]     inflight_q, inflight_d;
   logic              err_q, err_d;
   logic              accIssue, resAccept, full, push, pop;
   logic [DWIDTH-1:0] ramData;
   err_cause_e        errCause;

   // resv counts stored plus in-flight items, so a credit is only granted for a free slot.
   assign issue_ok_o = (resv_q < CW'(DEPTH));
   assign accIssue   = issue_i & issue_ok_o;
   assign full       = (count_q == CW'(DEPTH));
   assign pop        = (count_q != '0) & out_ready_i;
   assign resAccept  = res_valid_i & (inflight_q != '0);
   assign push       = resAccept & (~full | pop);

   always_comb begin
      count_d    = count_q;
      resv_d     = resv_q;
      inflight_d = inflight_q;
      case ({push, pop})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
      case ({accIssue, pop})
         2'b10:   resv_d = resv_q + 1'b1;
         2'b01:   resv_d = resv_q - 1'b1;
         default: resv_d = resv_q;
      endcase
      case ({accIssue, resAccept})
         2'b10:   inflight_d = inflight_q + 1'b1;
         2'b01:   inflight_d = inflight_q - 1'b1;
         default: inflight_d = inflight_q;
      endcase
   end

   always_comb begin
      errCause = ERR_NONE;
      if (issue_i && !issue_ok_o) begin
         errCause = ERR_CREDIT;
      end else if (res_valid_i && (inflight_q == '0)) begin
         errCause = ERR_ORPHAN;
      end else if (resAccept && full && !pop) begin
         errCause = ERR_OVERFLOW;
      end
      err_d = err_q | (errCause != ERR_NONE);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count_q    <= '0;
         resv_q     <= '0;
         inflight_q <= '0;
         err_q      <= 1'b0;
      end else begin
         count_q    <= count_d;
         resv_q     <= resv_d;
         inflight_q <= inflight_d;
         err_q      <= err_d;
      end
   end

   coef_fifo_ram #(
      .DWIDTH (DWIDTH),
      .DEPTH  (DEPTH)
   ) u_ram (
      .clk       (clk),
      .rst_n     (rst_n),
      .push_i    (push),
      .pop_i     (pop),
      .wr_data_i (res_data_i),
      .rd_data_o (ramData)
   );

   assign out_valid_o = (count_q != '0);
   assign out_data_o  = out_valid_o ? ramData : '0;
   assign count_o     = count_q;
   assign err_o       = err_q;

   // An overflow drop breaks the bookkeeping on purpose, so checks stop once err is set.
   a_resv_sum: assert property (@(posedge clk) disable iff (!rst_n || err_q)
      int'(resv_q) == int'(count_q) + int'(inflight_q));
   a_count_max: assert property (@(posedge clk) disable iff (!rst_n)
      int'(count_q) <= DEPTH);
   a_inflight_max: assert property (@(posedge clk) disable iff (!rst_n || err_q)
      int'(inflight_q) <= LAT);

endmodule

// File: tb/tb_coef_drain_fifo.sv
// Directed bench for coef_drain_fifo with a 3-cycle pipe model in front of it.
// A vector table covers backpressure; hand sequences cover the multi-cycle corners.
module tb_coef_drain_fifo;

   logic        clk;
   logic        rst_n;
   logic        issue_i;
   logic        issue_ok_o;
   logic        res_valid_i;
   logic [11:0] res_data_i;
   logic        out_valid_o;
   logic [11:0] out_data_o;
   logic        out_ready_i;
   logic [2:0]  count_o;
   logic        err_o;

   int          nChecks = 0;
   int          nFails  = 0;
   int          cycle   = 0;
   int          resvM   = 0;
   int          popped  = 0;
   bit          track   = 0;
   logic [11:0] nextData = '0;
   logic        pipeV [3];
   logic [11:0] pipeD [3];
   logic [11:0] sb [$];

   typedef struct {
      logic        issue;
      logic        ready;
      logic        expValid;
      logic [11:0] expData;
      logic [2:0]  expCount;
      logic        expOk;
      logic        expErr;
   } vec_t;

   vec_t vecs [13];

   coef_drain_fifo #(
      .DWIDTH (12),
      .LAT    (3),
      .DEPTH  (4)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .issue_i     (issue_i),
      .issue_ok_o  (issue_ok_o),
      .res_valid_i (res_valid_i),
      .res_data_i  (res_data_i),
      .out_valid_o (out_valid_o),
      .out_data_o  (out_data_o),
      .out_ready_i (out_ready_i),
      .count_o     (count_o),
      .err_o       (err_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      nChecks++;
      if (act !== exp) begin
         nFails++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic applyStimulus(input logic issue, input logic ready);
      issue_i     = issue;
      out_ready_i = ready;
   endtask

   // One clock: note what the DUT accepts/pops this cycle, then advance the pipe model.
   task automatic tick();
      logic        acc;
      logic        popNow;
      logic [11:0] accD;
      acc    = issue_i & issue_ok_o;
      popNow = out_valid_o & out_ready_i;
      accD   = nextData;
      if (acc) begin
         nextData = nextData + 12'd1;
         resvM++;
         if (track) sb.push_back(accD);
      end
      if (popNow) begin
         resvM--;
         popped++;
         if (track) begin
            if (sb.size() == 0) begin
               nChecks++;
               nFails++;
               $display("[TB] FAIL popData: got 0x%0h, expected no pop (scoreboard empty)", out_data_o);
            end else begin
               checkOutput("popData", out_data_o, sb.pop_front());
            end
         end
      end
      @(posedge clk);
      #1;
      pipeV[2] = pipeV[1];  pipeD[2] = pipeD[1];
      pipeV[1] = pipeV[0];  pipeD[1] = pipeD[0];
      pipeV[0] = acc;       pipeD[0] = accD;
      res_valid_i = pipeV[2];
      res_data_i  = pipeV[2] ? pipeD[2] : 12'h5A5;
      cycle++;
   endtask

   task automatic doReset();
      rst_n       = 1'b0;
      issue_i     = 1'b0;
      out_ready_i = 1'b0;
      res_valid_i = 1'b0;
      res_data_i  = '0;
      for (int i = 0; i < 3; i++) begin
         pipeV[i] = 1'b0;
         pipeD[i] = '0;
      end
      resvM  = 0;
      popped = 0;
      sb.delete();
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   initial begin
      int firstIss;
      int firstValid;
      int guard;

      // Backpressure: 4 credits, an illegal 5th issue, then a 4-cycle drain.
      vecs[0]  = '{1'b1, 1'b0, 1'b0, 12'h000, 3'd0, 1'b1, 1'b0};
      vecs[1]  = '{1'b1, 1'b0, 1'b0, 12'h000, 3'd0, 1'b1, 1'b0};
      vecs[2]  = '{1'b1, 1'b0, 1'b0, 12'h000, 3'd0, 1'b1, 1'b0};
      vecs[3]  = '{1'b1, 1'b0, 1'b0, 12'h000, 3'd0, 1'b1, 1'b0};
      vecs[4]  = '{1'b1, 1'b0, 1'b1, 12'hB00, 3'd1, 1'b0, 1'b0};
      vecs[5]  = '{1'b0, 1'b0, 1'b1, 12'hB00, 3'd2, 1'b0, 1'b1};
      vecs[6]  = '{1'b0, 1'b0, 1'b1, 12'hB00, 3'd3, 1'b0, 1'b1};
      vecs[7]  = '{1'b0, 1'b0, 1'b1, 12'hB00, 3'd4, 1'b0, 1'b1};
      vecs[8]  = '{1'b0, 1'b1, 1'b1, 12'hB00, 3'd4, 1'b0, 1'b1};
      vecs[9]  = '{1'b0, 1'b1, 1'b1, 12'hB01, 3'd3, 1'b1, 1'b1};
      vecs[10] = '{1'b0, 1'b1, 1'b1, 12'hB02, 3'd2, 1'b1, 1'b1};
      vecs[11] = '{1'b0, 1'b1, 1'b1, 12'hB03, 3'd1, 1'b1, 1'b1};
      vecs[12] = '{1'b0, 1'b0, 1'b0, 12'h000, 3'd0, 1'b1, 1'b1};

      doReset();
      checkOutput("reset out_valid", out_valid_o, 0);
      checkOutput("reset out_data", out_data_o, 0);
      checkOutput("reset count", count_o, 0);
      checkOutput("reset issue_ok", issue_ok_o, 1);
      checkOutput("reset err", err_o, 0);

      // Throughput with the consumer always ready.
      doReset();
      nextData    = 12'h000;
      track       = 1;
      firstIss    = -1;
      firstValid  = -1;
      out_ready_i = 1'b1;
      guard       = 0;
      while (popped < 10 && guard < 60) begin
         issue_i = (nextData < 12'd10) && issue_ok_o;
         checkOutput("tput issue_ok", issue_ok_o, (resvM < 4));
         if (firstIss < 0 && issue_i) firstIss = cycle;
         if (firstValid < 0 && out_valid_o) firstValid = cycle;
         tick();
         guard++;
      end
      issue_i = 1'b0;
      checkOutput("tput popped", popped, 10);
      checkOutput("tput latency", firstValid - firstIss, 4);
      checkOutput("tput sb empty", sb.size(), 0);
      checkOutput("tput count", count_o, 0);
      checkOutput("tput err", err_o, 0);

      // Vector table: backpressure and credit-error.
      doReset();
      nextData = 12'hB00;
      track    = 0;
      for (int k = 0; k < 13; k++) begin
         applyStimulus(vecs[k].issue, vecs[k].ready);
         checkOutput($sformatf("vec%0d out_valid", k), out_valid_o, vecs[k].expValid);
         checkOutput($sformatf("vec%0d out_data", k), out_data_o, vecs[k].expData);
         checkOutput($sformatf("vec%0d count", k), count_o, vecs[k].expCount);
         checkOutput($sformatf("vec%0d issue_ok", k), issue_ok_o, vecs[k].expOk);
         checkOutput($sformatf("vec%0d err", k), err_o, vecs[k].expErr);
         tick();
      end

      // Simultaneous push and pop at count 2.
      doReset();
      nextData = 12'hB20;
      track    = 1;
      applyStimulus(1'b1, 1'b0);
      tick(); tick(); tick();
      applyStimulus(1'b0, 1'b0);
      tick(); tick();
      checkOutput("pp count before", count_o, 2);
      checkOutput("pp res_valid arriving", res_valid_i, 1);
      applyStimulus(1'b0, 1'b1);
      tick();
      checkOutput("pp count after", count_o, 2);
      checkOutput("pp head", out_data_o, 12'hB21);
      guard = 0;
      while (popped < 3 && guard < 20) begin
         tick();
         guard++;
      end
      checkOutput("pp popped", popped, 3);
      checkOutput("pp count end", count_o, 0);
      checkOutput("pp err", err_o, 0);

      // Reset mid-stream with count 3 and one result still in the pipe.
      doReset();
      nextData = 12'hC00;
      track    = 0;
      applyStimulus(1'b1, 1'b0);
      tick(); tick(); tick(); tick();
      applyStimulus(1'b0, 1'b0);
      tick(); tick();
      checkOutput("mid count before", count_o, 3);
      rst_n = 1'b0;
      #1;
      checkOutput("mid out_valid in reset", out_valid_o, 0);
      checkOutput("mid out_data in reset", out_data_o, 0);
      checkOutput("mid count in reset", count_o, 0);
      rst_n = 1'b1;
      resvM = 0;
      #1;
      checkOutput("mid issue_ok after release", issue_ok_o, 1);
      tick();
      checkOutput("mid late result err", err_o, 1);
      checkOutput("mid late result count", count_o, 0);
      checkOutput("mid late result out_valid", out_valid_o, 0);

      // Result with nothing in flight.
      doReset();
      checkOutput("orphan err before", err_o, 0);
      res_valid_i = 1'b1;
      res_data_i  = 12'hEEE;
      tick();
      checkOutput("orphan err", err_o, 1);
      checkOutput("orphan count", count_o, 0);
      checkOutput("orphan out_valid", out_valid_o, 0);

      // Wrap with a randomly stalling consumer.
      doReset();
      nextData = 12'hD00;
      track    = 1;
      guard    = 0;
      while (popped < 13 && guard < 300) begin
         issue_i     = (nextData < 12'hD0D) && issue_ok_o;
         out_ready_i = 1'($urandom_range(0, 1));
         checkOutput("wrap issue_ok", issue_ok_o, (resvM < 4));
         tick();
         guard++;
      end
      applyStimulus(1'b0, 1'b0);
      checkOutput("wrap popped", popped, 13);
      checkOutput("wrap issued", nextData, 12'hD0D);
      checkOutput("wrap sb empty", sb.size(), 0);
      checkOutput("wrap count", count_o, 0);
      checkOutput("wrap err", err_o, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
      $finish;
   end

endmodule
